// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement controller: buffers W/A/S/D turn requests and advances the
// sprite one STEP per frame along tile-aligned corridors, stopping at walls.
module pacman_move_ctrl #(
  parameter int START_X       = 320,
  parameter int START_Y       = 240,
  parameter int TILE          = 16,
  parameter int STEP          = 1,
  parameter int X_MAX         = 640,
  parameter int BUFFER_FRAMES = 8
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       wall_up,
  input  logic       wall_down,
  input  logic       wall_left,
  input  logic       wall_right,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] dir,
  output logic       moving
);

  localparam int         TILE_BITS = $clog2(TILE);
  localparam int         AGE_W     = (BUFFER_FRAMES > 1) ? $clog2(BUFFER_FRAMES) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(BUFFER_FRAMES - 1);
  localparam logic [9:0] STEP_V    = 10'(STEP);
  localparam logic [9:0] X_WRAP    = 10'(X_MAX - STEP);
  localparam logic [9:0] RST_X     = 10'(START_X);
  localparam logic [9:0] RST_Y     = 10'(START_Y);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  logic [9:0]       pos_x_reg, pos_x_next;
  logic [9:0]       pos_y_reg, pos_y_next;
  logic [1:0]       dir_reg, dir_next;
  logic             moving_reg, moving_next;
  logic             started_reg, started_next;
  logic             req_valid_reg, req_valid_next;
  logic [1:0]       req_dir_reg, req_dir_next;
  logic [AGE_W-1:0] req_age_reg, req_age_next;

  logic       key_valid;
  logic [1:0] key_dir;
  logic [3:0] walls;
  logic       aligned;
  logic       req_reverse;
  logic       turn;
  logic [1:0] dir_post;
  logic       advance;

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_UP;
    case (keycode)
      8'h1A:   key_dir = DIR_UP;
      8'h16:   key_dir = DIR_DOWN;
      8'h04:   key_dir = DIR_LEFT;
      8'h07:   key_dir = DIR_RIGHT;
      default: key_valid = 1'b0;
    endcase
  end

  // Indexed by direction encoding so walls[d] is the flag for heading d.
  assign walls   = {wall_right, wall_left, wall_down, wall_up};
  assign aligned = (pos_x_reg[TILE_BITS-1:0] == '0) && (pos_y_reg[TILE_BITS-1:0] == '0);

  // A reversal never needs a tile boundary: the sprite just backs up its own corridor.
  assign req_reverse = (req_dir_reg == (dir_reg ^ 2'b01));
  assign turn        = req_valid_reg && (req_reverse || (aligned && !walls[req_dir_reg]));
  assign dir_post    = turn ? req_dir_reg : dir_reg;
  assign advance     = (started_reg || turn) && !(aligned && walls[dir_post]);

  always_comb begin
    pos_x_next     = pos_x_reg;
    pos_y_next     = pos_y_reg;
    dir_next       = dir_reg;
    moving_next    = moving_reg;
    started_next   = started_reg;
    req_valid_next = req_valid_reg;
    req_dir_next   = req_dir_reg;
    req_age_next   = req_age_reg;

    if (frame_tick) begin
      dir_next     = dir_post;
      started_next = started_reg || turn;
      moving_next  = advance;
      if (advance) begin
        case (dir_post)
          DIR_UP:    pos_y_next = pos_y_reg - STEP_V;
          DIR_DOWN:  pos_y_next = pos_y_reg + STEP_V;
          DIR_LEFT:  pos_x_next = (pos_x_reg == 10'd0) ? X_WRAP : pos_x_reg - STEP_V;
          default:   pos_x_next = (pos_x_reg == X_WRAP) ? 10'd0 : pos_x_reg + STEP_V;
        endcase
      end
      if (turn) begin
        req_valid_next = 1'b0;
        req_age_next   = '0;
      end else if (req_valid_reg) begin
        if (req_age_reg == AGE_LAST) begin
          req_valid_next = 1'b0;
          req_age_next   = '0;
        end else begin
          req_age_next = req_age_reg + 1'b1;
        end
      end
    end

    // A fresh key wins over whatever the tick did to the old request.
    if (key_valid) begin
      req_valid_next = 1'b1;
      req_dir_next   = key_dir;
      req_age_next   = '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pos_x_reg     <= RST_X;
      pos_y_reg     <= RST_Y;
      dir_reg       <= DIR_LEFT;
      moving_reg    <= 1'b0;
      started_reg   <= 1'b0;
      req_valid_reg <= 1'b0;
      req_dir_reg   <= DIR_UP;
      req_age_reg   <= '0;
    end else begin
      pos_x_reg     <= pos_x_next;
      pos_y_reg     <= pos_y_next;
      dir_reg       <= dir_next;
      moving_reg    <= moving_next;
      started_reg   <= started_next;
      req_valid_reg <= req_valid_next;
      req_dir_reg   <= req_dir_next;
      req_age_reg   <= req_age_next;
    end
  end

  assign pos_x  = pos_x_reg;
  assign pos_y  = pos_y_reg;
  assign dir    = dir_reg;
  assign moving = moving_reg;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl: turn buffering, expiry, walls, tunnel
// wrap and reset; expected positions are hand-computed per step.
module tb_pacman_move_ctrl;

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       wall_up = 1'b0;
  logic       wall_down = 1'b0;
  logic       wall_left = 1'b0;
  logic       wall_right = 1'b0;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [1:0] dir;
  logic       moving;

  int cmp_cnt = 0;
  int fail_cnt = 0;

  pacman_move_ctrl dut (
    .vga_clk    (vga_clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .wall_up    (wall_up),
    .wall_down  (wall_down),
    .wall_left  (wall_left),
    .wall_right (wall_right),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .dir        (dir),
    .moving     (moving)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int x, input int y, input int d, input int m);
    check({tag, ".pos_x"}, 32'(pos_x), x);
    check({tag, ".pos_y"}, 32'(pos_y), y);
    check({tag, ".dir"}, 32'(dir), d);
    check({tag, ".moving"}, 32'(moving), m);
    $display("step %-14s pos=(%0d,%0d) dir=%0d moving=%0d", tag, pos_x, pos_y, dir, moving);
  endtask

  task automatic tick();
    @(negedge vga_clk);
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
  endtask

  task automatic press(input logic [7:0] k);
    @(negedge vga_clk);
    keycode = k;
    @(negedge vga_clk);
    keycode = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge vga_clk);
    Reset = 1'b1;
    keycode = 8'h00;
    frame_tick = 1'b0;
    {wall_up, wall_down, wall_left, wall_right} = 4'b0000;
    @(negedge vga_clk);
    @(negedge vga_clk);
    Reset = 1'b0;
  endtask

  initial begin
    // Reset and idle ticks: nothing moves before the first accepted key.
    do_reset();
    check_state("reset", 320, 240, 2, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state("idle_tick", 320, 240, 2, 0);
    end
    press(8'h05);
    tick();
    check_state("invalid_key", 320, 240, 2, 0);
    press(8'h16);
    tick();
    check_state("down", 320, 241, 1, 1);
    repeat (3) @(negedge vga_clk);
    check_state("stable", 320, 241, 1, 1);

    // Start right, three ticks.
    do_reset();
    press(8'h07);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_state("right", 320 + i, 240, 3, 1);
    end

    // Held W key: turn happens only once the sprite reaches x=336.
    @(negedge vga_clk);
    keycode = 8'h1A;
    for (int i = 0; i < 13; i++) begin
      tick();
      check_state("held_w", 324 + i, 240, 3, 1);
    end
    tick();
    check_state("turn_up", 336, 239, 0, 1);
    keycode = 8'h00;

    // Expiry: a press at x=328 dies before x=336; a press at x=345 survives to x=352.
    do_reset();
    press(8'h07);
    for (int i = 0; i < 8; i++) tick();
    check_state("at_328", 328, 240, 3, 1);
    press(8'h1A);
    for (int i = 0; i < 8; i++) tick();
    check_state("exp_336", 336, 240, 3, 1);
    tick();
    check_state("expired", 337, 240, 3, 1);
    for (int i = 0; i < 8; i++) tick();
    check_state("at_345", 345, 240, 3, 1);
    press(8'h1A);
    for (int i = 0; i < 7; i++) tick();
    check_state("buf_352", 352, 240, 3, 1);
    tick();
    check_state("buf_turn", 352, 239, 0, 1);

    // Walls: blocked forward motion, blocked turn, then reversal.
    do_reset();
    wall_right = 1'b1;
    press(8'h07);
    tick();
    check_state("wall_r", 320, 240, 3, 0);
    tick();
    check_state("wall_r2", 320, 240, 3, 0);
    wall_up = 1'b1;
    press(8'h1A);
    tick();
    check_state("wall_up", 320, 240, 3, 0);
    press(8'h04);
    tick();
    check_state("reverse", 319, 240, 2, 1);
    {wall_up, wall_right} = 2'b00;

    // Tunnel wrap both ways.
    do_reset();
    press(8'h04);
    for (int i = 0; i < 320; i++) tick();
    check_state("at_zero", 0, 240, 2, 1);
    tick();
    check_state("wrap_left", 639, 240, 2, 1);
    press(8'h07);
    tick();
    check_state("wrap_right", 0, 240, 3, 1);

    // Reset coincident with a tick while a request is pending.
    press(8'h1A);
    @(negedge vga_clk);
    Reset = 1'b1;
    frame_tick = 1'b1;
    @(negedge vga_clk);
    Reset = 1'b0;
    frame_tick = 1'b0;
    check_state("rst_tick", 320, 240, 2, 0);
    tick();
    check_state("post_rst", 320, 240, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
